patch_scheduler: RTL and testbench
==================================

Name: patch_scheduler

Overview:
- Sequences one patchifier instance across a full image: walks patch tiles in raster order, requests each tile from the patch-cache loader, launches the patchifier, and hands the vectorized patch to the downstream embedding stage.
- Sits between the image buffer / cache loader and the patchifier.
- Owns all `en`/`output_taken` traffic to the patchifier.

Parameters:
- IMG_W, 224, image width in pixels; multiple of PATCH_SIZE.
- IMG_H, 224, image height in pixels; multiple of PATCH_SIZE.
- PATCH_SIZE, 16, patch edge in pixels; must match the patchifier instance.
- PATCHES_X, IMG_W/PATCH_SIZE, derived, patch columns.
- PATCHES_Y, IMG_H/PATCH_SIZE, derived, patch rows.
- NUM_PATCHES, PATCHES_X*PATCHES_Y, derived.
- IDX_W, $clog2(NUM_PATCHES), derived, patch index width; minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins an image pass when idle.
- busy  out  1  high from the accepted start until the cycle done pulses.
- done  out  1  one-cycle pulse after the last patch is accepted downstream.
- load_req  out  1  request to the cache loader to fill the tile at patch_row/patch_col.
- load_ack  in  1  one-cycle pulse: the patchifier's patch_cache input is valid and stable.
- patch_row  out  $clog2(PATCHES_Y) (min 1)  current tile row.
- patch_col  out  $clog2(PATCHES_X) (min 1)  current tile column.
- patch_index  out  IDX_W  row*PATCHES_X+col; tags the outgoing patch.
- pf_en  out  1  patchifier enable.
- pf_output_taken  out  1  patchifier output_taken.
- pf_state  in  2  patchifier state (IDLE/PROCESSING/DONE encoding from the package).
- out_valid  out  1  the patchifier's vectorized_patch is valid for patch_index.
- out_ready  in  1  downstream accepts the patch.

Behaviour:
- Reset (reset low, asynchronous): FSM=S_IDLE; row=col=0; every output 0.
- States: S_IDLE, S_LOAD, S_LAUNCH, S_WAIT, S_SETTLE, S_OUT.
- S_IDLE:
  - start=1 -> S_LOAD; busy=1; row=col=0.
  - start while busy is ignored.
- S_LOAD:
  - load_req=1 (held level).
  - Stays in S_LOAD until load_ack=1, then -> S_LAUNCH.
  - load_ack outside S_LOAD is ignored.
- S_LAUNCH:
  - pf_en=1 only while pf_state==PF_IDLE; otherwise waits with pf_en=0.
  - pf_en is asserted for exactly one cycle, then -> S_WAIT.
  - The patch cache must stay stable through that cycle, because the patchifier captures it on the en edge.
- S_WAIT: waits for pf_state==PF_DONE, then -> S_SETTLE.
- S_SETTLE:
  - Exactly one cycle, because the patchifier registers its output on its first DONE cycle.
  - -> S_OUT.
- S_OUT:
  - out_valid=1; patch_row/patch_col/patch_index held stable.
  - On out_valid&&out_ready: pf_output_taken=1 that same cycle (combinational from the handshake; this cycle is the only place it is asserted); out_valid drops next cycle.
  - Not the last patch: advance col; on col==PATCHES_X-1, col=0 and row++; -> S_LOAD.
  - Last patch (row==PATCHES_Y-1 and col==PATCHES_X-1): done=1 next cycle, busy=0 the same cycle; -> S_IDLE.
- Backpressure: out_ready low holds S_OUT indefinitely; the patchifier stays in DONE.
- Latency: one cycle from start to load_req; two cycles from patchifier DONE to out_valid.
- start coincident with done is ignored; a new start is accepted only from the cycle after done.
- Reset mid-pass: returns to idle immediately. The system resets the patchifier together with this block.
- Single-patch image (NUM_PATCHES=1): done follows the first handshake.

Optional Feature:
- Macro: PATCH_SCHED_PERF_EN.
- Defined:
  - Adds output stall_cycles [31:0]: count of cycles in S_OUT with out_ready=0 plus cycles in S_LOAD, accumulated over the current pass.
  - Cleared on accepted start; holds its value after done; saturates at all-ones.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package patch_pkg:
  - PF_IDLE=2'b00, PF_PROCESSING=2'b01, PF_DONE=2'b10.
  - Scheduler state enum.
  - Shared PATCH_SIZE / PIXEL_WIDTH constants used by patchifier and scheduler.
- Sub-module patch_tile_counter: row/col/index counter with inc, clr and last outputs.

Test Plan:
- IMG 32x32, PATCH 16, patchifier model, out_ready=1, load_ack 3 cycles after load_req -> 4 handshakes in order:
  - patch_index 0,1,2,3;
  - (row,col) = (0,0),(0,1),(1,0),(1,1);
  - done pulses once;
  - pf_en and pf_output_taken each pulse exactly 4 times.
- Latency check -> out_valid rises exactly 2 cycles after pf_state first reads PF_DONE, and the sampled vector equals the loaded tile.
- out_ready held low 10 cycles on patch 1 -> out_valid and index held stable, no pf_output_taken, stall_cycles grows by 10 (with PATCH_SCHED_PERF_EN).
- start pulsed mid-pass and coincident with done -> ignored; the pass still yields 4 patches; a new start one cycle after done begins at index 0.
- reset low during S_WAIT on patch 2 -> all outputs 0 immediately (asynchronously); after release and a new start, the first index is 0.
- IMG 16x16 (NUM_PATCHES=1) -> one handshake, done one cycle later.

Source files
------------

// File: rtl/patch_pkg.sv
// Shared patch-pipeline types: patchifier state encoding, scheduler FSM states
// and the pixel/patch geometry constants common to patchifier and scheduler.
package patch_pkg;

    localparam int PATCH_SIZE  = 16;
    localparam int PIXEL_WIDTH = 8;

    typedef enum logic [1:0] {
        PF_IDLE       = 2'b00,
        PF_PROCESSING = 2'b01,
        PF_DONE       = 2'b10
    } pf_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LAUNCH,
        S_WAIT,
        S_SETTLE,
        S_OUT
    } sched_state_e;

    // Counter width that stays at least one bit for degenerate single-tile axes.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/patch_tile_counter.sv
// Raster-order tile walker: column-fastest row/col position plus a running
// linear patch index; wraps to (0,0) after the last tile.
module patch_tile_counter #(
    parameter int PATCHES_X = 14,
    parameter int PATCHES_Y = 14,
    parameter int ROW_W     = patch_pkg::clog2_min1(PATCHES_Y),
    parameter int COL_W     = patch_pkg::clog2_min1(PATCHES_X),
    parameter int IDX_W     = patch_pkg::clog2_min1(PATCHES_X * PATCHES_Y)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic [IDX_W-1:0] index,
    output logic             last
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(PATCHES_X - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PATCHES_Y - 1);

    logic [ROW_W-1:0] row_reg, row_next;
    logic [COL_W-1:0] col_reg, col_next;
    logic [IDX_W-1:0] index_reg, index_next;
    logic             col_last;

    assign col_last = (col_reg == COL_LAST);
    assign last     = col_last && (row_reg == ROW_LAST);

    always_comb begin
        row_next   = row_reg;
        col_next   = col_reg;
        index_next = index_reg;
        if (clr) begin
            row_next   = '0;
            col_next   = '0;
            index_next = '0;
        end else if (inc) begin
            if (last) begin
                row_next   = '0;
                col_next   = '0;
                index_next = '0;
            end else if (col_last) begin
                row_next   = row_reg + ROW_W'(1);
                col_next   = '0;
                index_next = index_reg + IDX_W'(1);
            end else begin
                col_next   = col_reg + COL_W'(1);
                index_next = index_reg + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_reg   <= '0;
            col_reg   <= '0;
            index_reg <= '0;
        end else begin
            row_reg   <= row_next;
            col_reg   <= col_next;
            index_reg <= index_next;
        end
    end

    assign row   = row_reg;
    assign col   = col_reg;
    assign index = index_reg;

endmodule

// File: rtl/patch_scheduler.sv
// Walks every patch tile of an image through one patchifier: load, launch, wait,
// settle, hand off downstream. Optional stall counter under PATCH_SCHED_PERF_EN.
module patch_scheduler #(
    parameter int IMG_W       = 224,
    parameter int IMG_H       = 224,
    parameter int PATCH_SIZE  = patch_pkg::PATCH_SIZE,
    parameter int PATCHES_X   = IMG_W / PATCH_SIZE,
    parameter int PATCHES_Y   = IMG_H / PATCH_SIZE,
    parameter int NUM_PATCHES = PATCHES_X * PATCHES_Y,
    parameter int IDX_W       = patch_pkg::clog2_min1(NUM_PATCHES),
    parameter int ROW_W       = patch_pkg::clog2_min1(PATCHES_Y),
    parameter int COL_W       = patch_pkg::clog2_min1(PATCHES_X)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             load_req,
    input  logic             load_ack,
    output logic [ROW_W-1:0] patch_row,
    output logic [COL_W-1:0] patch_col,
    output logic [IDX_W-1:0] patch_index,
    output logic             pf_en,
    output logic             pf_output_taken,
    input  logic [1:0]       pf_state,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PATCH_SCHED_PERF_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    import patch_pkg::*;

    sched_state_e state_reg, state_next;
    logic         done_reg, done_next;
    logic         start_accept;
    logic         tile_clr, tile_inc, tile_last;

    // A start landing on the done cycle belongs to the finished pass.
    assign start_accept = (state_reg == S_IDLE) && start && !done_reg;

    patch_tile_counter #(
        .PATCHES_X (PATCHES_X),
        .PATCHES_Y (PATCHES_Y),
        .ROW_W     (ROW_W),
        .COL_W     (COL_W),
        .IDX_W     (IDX_W)
    ) u_tile_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (tile_clr),
        .inc   (tile_inc),
        .row   (patch_row),
        .col   (patch_col),
        .index (patch_index),
        .last  (tile_last)
    );

    always_comb begin
        state_next      = state_reg;
        done_next       = 1'b0;
        tile_clr        = 1'b0;
        tile_inc        = 1'b0;
        load_req        = 1'b0;
        pf_en           = 1'b0;
        pf_output_taken = 1'b0;
        out_valid       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start_accept) begin
                    tile_clr   = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                load_req = 1'b1;
                if (load_ack) begin
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // The cache stays stable here; the patchifier captures it on this en edge.
                if (pf_state == PF_IDLE) begin
                    pf_en      = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pf_state == PF_DONE) begin
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Patchifier registers its output during its first DONE cycle.
                state_next = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    pf_output_taken = 1'b1;
                    tile_inc        = 1'b1;
                    if (tile_last) begin
                        done_next  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_LOAD;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    assign busy = (state_reg != S_IDLE);
    assign done = done_reg;

`ifdef PATCH_SCHED_PERF_EN
    logic [31:0] stall_reg;
    logic        stall_event;

    assign stall_event = (state_reg == S_LOAD) || ((state_reg == S_OUT) && !out_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_reg <= '0;
        end else if (start_accept) begin
            stall_reg <= '0;
        end else if (stall_event && (stall_reg != '1)) begin
            stall_reg <= stall_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_patch_scheduler.sv
// Self-checking bench for patch_scheduler: 2x2-tile image with loader and
// patchifier models plus a cycle-level reference, and a single-tile instance.
`timescale 1ns/1ps
module tb_patch_scheduler;
    import patch_pkg::*;

    localparam int PX = 2;
    localparam int PY = 2;
    localparam int NP = PX * PY;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start, busy, done, load_req, load_ack;
    logic [0:0] patch_row, patch_col;
    logic [1:0] patch_index;
    logic       pf_en, pf_output_taken, out_valid, out_ready;
    logic [1:0] pf_state;

    logic       s_start, s_busy, s_done, s_load_req, s_load_ack;
    logic [0:0] s_patch_row, s_patch_col, s_patch_index;
    logic       s_pf_en, s_pf_output_taken, s_out_valid, s_out_ready;
    logic [1:0] s_pf_state;
`ifdef PATCH_SCHED_PERF_EN
    logic [31:0] stall_cycles, s_stall_cycles;
`endif

    patch_scheduler #(.IMG_W(32), .IMG_H(32), .PATCH_SIZE(16)) dut (
        .clk(clk), .reset(rst_n), .start(start), .busy(busy), .done(done),
        .load_req(load_req), .load_ack(load_ack), .patch_row(patch_row),
        .patch_col(patch_col), .patch_index(patch_index), .pf_en(pf_en),
        .pf_output_taken(pf_output_taken), .pf_state(pf_state),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef PATCH_SCHED_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    patch_scheduler #(.IMG_W(16), .IMG_H(16), .PATCH_SIZE(16)) dut1 (
        .clk(clk), .reset(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
        .load_req(s_load_req), .load_ack(s_load_ack), .patch_row(s_patch_row),
        .patch_col(s_patch_col), .patch_index(s_patch_index), .pf_en(s_pf_en),
        .pf_output_taken(s_pf_output_taken), .pf_state(s_pf_state),
        .out_valid(s_out_valid), .out_ready(s_out_ready)
`ifdef PATCH_SCHED_PERF_EN
        , .stall_cycles(s_stall_cycles)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [31:0] tile_val(input int r, input int c);
        return 32'hC0DE_0000 | 32'(r << 8) | 32'(c);
    endfunction

    // Cache loader model: garbage while filling, tile contents when acking.
    int          ack_delay = 3;
    bit          rand_delay = 1'b0;
    int          ld_wait, ld_tgt;
    logic [31:0] cache;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_ack <= 1'b0;
            ld_wait  <= 0;
            cache    <= 32'hDEAD_BEEF;
        end else begin
            load_ack <= 1'b0;
            if (load_req && !load_ack) begin
                if (ld_wait == 0) begin
                    ld_tgt = rand_delay ? int'($urandom_range(1, 5)) : ack_delay;
                    cache <= $urandom;
                end
                if (ld_wait >= ld_tgt - 1) begin
                    load_ack <= 1'b1;
                    cache    <= tile_val(int'(patch_row), int'(patch_col));
                    ld_wait  <= 0;
                end else begin
                    ld_wait <= ld_wait + 1;
                end
            end
        end
    end

    // Patchifier model: captures cache on en, processes, registers output on first DONE cycle.
    int          proc_len = 4;
    bit          rand_proc = 1'b0;
    logic [1:0]  pf_st;
    logic [31:0] pf_cap, pf_vec;
    logic        pf_vec_ok;
    int          pf_cnt;
    assign pf_state = pf_st;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_st     <= PF_IDLE;
            pf_cap    <= '0;
            pf_vec    <= '0;
            pf_vec_ok <= 1'b0;
            pf_cnt    <= 0;
        end else begin
            case (pf_st)
                PF_IDLE: if (pf_en) begin
                    pf_cap <= cache;
                    pf_cnt <= rand_proc ? int'($urandom_range(0, 6)) : proc_len;
                    pf_st  <= PF_PROCESSING;
                end
                PF_PROCESSING: if (pf_cnt == 0) pf_st <= PF_DONE; else pf_cnt <= pf_cnt - 1;
                PF_DONE: begin
                    if (!pf_vec_ok) begin
                        pf_vec    <= pf_cap;
                        pf_vec_ok <= 1'b1;
                    end
                    if (pf_output_taken) begin
                        pf_st     <= PF_IDLE;
                        pf_vec_ok <= 1'b0;
                    end
                end
                default: pf_st <= PF_IDLE;
            endcase
        end
    end

    // Reference: expected handshake sequence, pass membership, done timing, stall total.
    int          cyc = 0, exp_k = 0, done_cyc = 0;
    int          hs_cnt = 0, en_cnt = 0, tk_cnt = 0, done_cnt = 0;
    bit          seen_done = 0, done_due = 0, model_busy = 0, prev_valid = 0, start_acc_prev = 0;
    logic [31:0] stall_model = '0;
    always @(negedge clk) begin
        bit nb, nd, ns;
        if (!rst_n) begin
            exp_k = 0; seen_done = 0; done_due = 0; model_busy = 0;
            prev_valid = 0; start_acc_prev = 0; stall_model = '0;
        end else begin
            cyc++;
            nb = model_busy; nd = 1'b0; ns = 1'b0;
            chk("busy", busy, model_busy);
            chk("done", done, done_due);
            if (start_acc_prev) chk("load_req_latency", load_req, 1);
            if (pf_en) begin
                en_cnt++;
                chk("pf_en_only_when_pf_idle", pf_state, PF_IDLE);
            end
            if (done) done_cnt++;
            if (pf_output_taken) tk_cnt++;
            if (pf_st == PF_DONE && !seen_done) begin
                seen_done = 1; done_cyc = cyc;
            end
            if (load_req) stall_model++;
            if (out_valid) begin
                if (!prev_valid) chk("done_to_valid_latency", cyc - done_cyc, 2);
                chk("patch_index", patch_index, exp_k);
                chk("patch_row", patch_row, exp_k / PX);
                chk("patch_col", patch_col, exp_k % PX);
                chk("vector", pf_vec, tile_val(exp_k / PX, exp_k % PX));
                chk("pf_output_taken", pf_output_taken, out_ready);
                if (!out_ready) stall_model++;
                else begin
                    hs_cnt++; seen_done = 0; exp_k++;
                    if (exp_k == NP) begin
                        exp_k = 0; nd = 1'b1; nb = 1'b0;
                    end
                end
            end else begin
                chk("pf_output_taken_idle", pf_output_taken, 0);
            end
`ifdef PATCH_SCHED_PERF_EN
            if (done) chk("stall_cycles_pass", stall_cycles, stall_model);
`endif
            if (start && !model_busy && !done_due) begin
                nb = 1'b1; ns = 1'b1; stall_model = '0;
            end
            prev_valid = out_valid;
            model_busy = nb; done_due = nd; start_acc_prev = ns;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (1) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
            if (n > 3000) begin
                n_cmp++; n_err++;
                $display("FAIL %s_done_timeout: got no done, required done within 3000 cycles", tag);
                break;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_load_req"}, load_req, 0);
        chk({tag, "_pf_en"}, pf_en, 0);
        chk({tag, "_pf_output_taken"}, pf_output_taken, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_patch_index"}, patch_index, 0);
        chk({tag, "_patch_row"}, patch_row, 0);
        chk({tag, "_patch_col"}, patch_col, 0);
    endtask

    initial begin
        int hs0, en0, tk0, dn0, n;
        logic [31:0] st0;
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        s_start = 1'b0; s_load_ack = 1'b0; s_pf_state = PF_IDLE; s_out_ready = 1'b0;
        st0 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset_s_busy", s_busy, 0);
        rst_n = 1'b1;

        // Pass 1: ready always high, ack 3 cycles after request.
        hs0 = hs_cnt; en0 = en_cnt; tk0 = tk_cnt; dn0 = done_cnt;
        pulse_start();
        wait_done("pass1");
        @(negedge clk); #1;
        chk("pass1_handshakes", hs_cnt - hs0, 4);
        chk("pass1_pf_en_pulses", en_cnt - en0, 4);
        chk("pass1_taken_pulses", tk_cnt - tk0, 4);
        chk("pass1_done_pulses", done_cnt - dn0, 1);

        // Pass 2: 10-cycle backpressure on patch 1, a start mid-pass, a start on done.
        hs0 = hs_cnt; dn0 = done_cnt;
        pulse_start();
        n = 0;
        while (!(load_req && patch_index == 2'd1) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        out_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 500);
        chk("bp_reached_patch1", patch_index, 1);
`ifdef PATCH_SCHED_PERF_EN
        st0 = stall_cycles;
`endif
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 3) start = 1'b1;
            if (i == 4) start = 1'b0;
            if (i == 9) out_ready = 1'b1;
        end
        @(negedge clk);
        chk("bp_index_held", patch_index, 1);
        chk("bp_taken_on_release", pf_output_taken, 1);
`ifdef PATCH_SCHED_PERF_EN
        chk("bp_stall_growth", stall_cycles - st0, 10);
`endif
        wait_done("pass2");
        start = 1'b1;
        @(posedge clk); #1;
        chk("start_on_done_ignored", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_after_done_accepted", busy, 1);
        chk("pass2_handshakes", hs_cnt - hs0, 4);
        chk("pass2_done_pulses", done_cnt - dn0, 1);
        wait_done("pass3");

        // Randomized passes: random ack delay, processing time and backpressure.
        rand_delay = 1'b1; rand_proc = 1'b1;
        for (int p = 0; p < 6; p++) begin
            hs0 = hs_cnt;
            pulse_start();
            n = 0;
            while (1) begin
                @(posedge clk); #1;
                n++;
                out_ready = ($urandom_range(0, 3) != 0);
                if (done) break;
                if (n > 3000) begin
                    n_cmp++; n_err++;
                    $display("FAIL rand_pass_done_timeout: got no done, required done within 3000 cycles");
                    break;
                end
            end
            @(negedge clk);
            chk("rand_pass_handshakes", hs_cnt - hs0, 4);
        end
        out_ready = 1'b1; rand_delay = 1'b0; rand_proc = 1'b0;

        // Asynchronous reset while waiting on patch 2.
        pulse_start();
        n = 0;
        while (!(patch_index == 2'd2 && pf_st == PF_PROCESSING) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk("mid_reset_reached_patch2", patch_index, 2);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk); #1 rst_n = 1'b1;
        pulse_start();
        n = 0;
        while (!out_valid && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk("after_reset_first_index", patch_index, 0);
        wait_done("after_reset");

        // Single-tile instance: hand-driven patchifier, also exercises launch stall.
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        chk("s_busy_after_start", s_busy, 1);
        chk("s_load_req_after_start", s_load_req, 1);
        s_pf_state = PF_PROCESSING;
        @(posedge clk); #1 s_load_ack = 1'b1;
        @(posedge clk); #1 s_load_ack = 1'b0;
        chk("s_launch_blocked_pf_en", s_pf_en, 0);
        chk("s_launch_load_req", s_load_req, 0);
        @(posedge clk); #1 s_pf_state = PF_IDLE;
        #1 chk("s_launch_pf_en", s_pf_en, 1);
        @(posedge clk); #1 s_pf_state = PF_PROCESSING;
        chk("s_wait_pf_en", s_pf_en, 0);
        @(posedge clk); #1 s_pf_state = PF_DONE;
        @(posedge clk); #1 chk("s_settle_out_valid", s_out_valid, 0);
        @(posedge clk); #1;
        chk("s_out_valid", s_out_valid, 1);
        chk("s_patch_index", s_patch_index, 0);
        chk("s_taken_before_ready", s_pf_output_taken, 0);
        s_out_ready = 1'b1;
        #1 chk("s_taken_on_handshake", s_pf_output_taken, 1);
        chk("s_done_early", s_done, 0);
        @(posedge clk); #1;
        chk("s_done_pulse", s_done, 1);
        chk("s_busy_at_done", s_busy, 0);
        chk("s_out_valid_dropped", s_out_valid, 0);
`ifdef PATCH_SCHED_PERF_EN
        chk("s_stall_cycles", s_stall_cycles, 2);
`endif
        s_out_ready = 1'b0; s_pf_state = PF_IDLE;
        @(posedge clk); #1 chk("s_done_one_cycle", s_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
